// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial add/subtract unit: FSM state encoding
// and operation select constants.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle of the bit-serial add/subtract unit.
// The ovf signal exists only when ADDSUB_OVF_EN is defined.
interface serial_addsub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
`ifdef ADDSUB_OVF_EN
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, carry_out, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, carry_out, ovf
    );
`else
    modport master (
        output start, sub, a, b,
        input  busy, done, result, carry_out
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, carry_out
    );
`endif
endinterface

// File: rtl/fulladder.sv
// Single-bit full adder cell used for the per-bit serial step.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    // Plain combinational full adder.
    always_comb begin
        sum       = a ^ b ^ carry_in;
        carry_out = (a & b) | (carry_in & (a ^ b));
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract unit: one full-adder cell and a carry flip-flop
// process the operands LSB first, one bit per clock.
// Optional signed overflow output enabled by defining ADDSUB_OVF_EN.
module serial_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_addsub_if.slave bus
);
    import arith_pkg::*;

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    // Partial sum lives here so result never shows an incomplete value.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
`ifdef ADDSUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_sum;
    logic fa_cout;

    fulladder u_fa (
        .a         (a_sh_q[0]),
        .b         (b_sh_q[0] ^ sub_q),
        .carry_in  (carry_q),
        .sum       (fa_sum),
        .carry_out (fa_cout)
    );

    // Next-state: operand capture on accept, one serial step per RUN cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef ADDSUB_OVF_EN
        ovf_d    = ovf_q;
`endif

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    sub_d   = bus.sub;
                    // Carry-in of 1 completes the two's-complement negation of b.
                    carry_d = (bus.sub == OP_SUB);
                    acc_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_cout;
                acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
                if (cnt_q == LAST_BIT) begin
                    state_d  = DONE;
                    result_d = acc_d;
                    cout_d   = fa_cout;
`ifdef ADDSUB_OVF_EN
                    // carry_q is the carry into the MSB during the last step.
                    ovf_d    = carry_q ^ fa_cout;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset that overrides any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sub_q    <= OP_ADD;
            carry_q  <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef ADDSUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef ADDSUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Status and result outputs decoded from registered state.
    always_comb begin
        bus.busy      = (state_q == RUN);
        bus.done      = (state_q == DONE);
        bus.result    = result_q;
        bus.carry_out = cout_q;
`ifdef ADDSUB_OVF_EN
        bus.ovf       = ovf_q;
`endif
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8). A cycle-level arithmetic
// model runs alongside the DUT; directed operations pin literal results.
module tb_serial_addsub;

    localparam int unsigned W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    bit   cmp_en;

    serial_addsub_if #(.WIDTH(W)) bus ();

    serial_addsub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: operation outcome from plain arithmetic, timing from a run countdown.
    int         m_run;
    logic       m_done;
    logic [W-1:0] m_result, p_result;
    logic       m_cout, p_cout;
    logic       m_ovf, p_ovf;

    function automatic logic [W+1:0] calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
        int sx, sy, sr;
        logic [W-1:0] r;
        logic c;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            r  = x - y;
            c  = (x >= y);
            sr = sx - sy;
        end else begin
            r  = x + y;
            c  = ((int'(x) + int'(y)) >= (1 << W));
            sr = sx + sy;
        end
        return {(sr > 127) || (sr < -128), c, r};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_run    <= 0;
            m_done   <= 1'b0;
            m_result <= '0;
            m_cout   <= 1'b0;
            m_ovf    <= 1'b0;
            p_result <= '0;
            p_cout   <= 1'b0;
            p_ovf    <= 1'b0;
        end else begin
            m_done <= (m_run == 1);
            if (m_run == 1) begin
                m_result <= p_result;
                m_cout   <= p_cout;
                m_ovf    <= p_ovf;
            end
            if (m_run > 0) begin
                m_run <= m_run - 1;
            end else if (bus.start) begin
                m_run <= W;
                {p_ovf, p_cout, p_result} <= calc(bus.a, bus.b, bus.sub);
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", int'(bus.busy), int'(m_run > 0));
            chk("done", int'(bus.done), int'(m_done));
            chk("result", int'(bus.result), int'(m_result));
            chk("carry_out", int'(bus.carry_out), int'(m_cout));
`ifdef ADDSUB_OVF_EN
            chk("ovf", int'(bus.ovf), int'(m_ovf));
`endif
        end
    end

    // Issue one op at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb2,
                          input logic ts, input logic [W-1:0] er, input logic ec,
                          input logic eo);
        int k;
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb2;
        bus.sub   = ts;
        @(negedge clk);
        k = 1;
        bus.start = 1'b0;
        bus.a     = ~ta;
        bus.b     = ~tb2;
        bus.sub   = ~ts;
        while (!bus.done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_latency"}, k, W + 1);
        chk({name, "_result"}, int'(bus.result), int'(er));
        chk({name, "_cout"}, int'(bus.carry_out), int'(ec));
`ifdef ADDSUB_OVF_EN
        chk({name, "_ovf"}, int'(bus.ovf), int'(eo));
`else
        if (eo === 1'bx) chk({name, "_ovf_arg"}, 0, 1);
`endif
    endtask

    initial begin
        int ndone;
        checks    = 0;
        failures  = 0;
        cmp_en    = 1'b0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_result", int'(bus.result), 0);
        chk("rst_cout", int'(bus.carry_out), 0);
        rst    = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);

        run_op("add_1_1", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
        run_op("add_ff_1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("sub_5_7", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("sub_7_5", 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0);
        run_op("add_7f_1", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("sub_80_1", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        repeat (3) @(negedge clk);

        // Ignored start mid-operation, then back-to-back issue from DONE.
        bus.start = 1'b1; bus.a = 8'd3; bus.b = 8'd4; bus.sub = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("ign_busy_c4", int'(bus.busy), 1);
        bus.start = 1'b1; bus.a = 8'd9; bus.b = 8'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("ign_done_c9", int'(bus.done), 1);
        chk("ign_result", int'(bus.result), 8'h07);
        bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.sub = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        chk("b2b_nodone_c17", int'(bus.done), 0);
        @(negedge clk);
        chk("b2b_done_c18", int'(bus.done), 1);
        chk("b2b_result", int'(bus.result), 8'h30);
        @(negedge clk);

        // Reset in the middle of an operation.
        bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22; bus.sub = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_done", int'(bus.done), 0);
        chk("mid_rst_result", int'(bus.result), 0);
        chk("mid_rst_cout", int'(bus.carry_out), 0);
        rst   = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("mid_rst_no_done", ndone, 0);
        run_op("post_rst_add", 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);
        run_op("sub_0_1", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);
        run_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial add/subtract unit for the processor datapath.
- Accepts two WIDTH-bit operands on a start pulse and computes a+b or a-b one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop.
- Pulses done with the result, final carry and (optionally) signed overflow.
- Serves as the small-area arithmetic path where a ripple adder is too large.

Parameters:
- WIDTH, 8, operand and result width in bits; legal values are 2 to 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the unit is not busy.
- sub  input  1  0 = a+b, 1 = a-b; latched with start.
- a  input  WIDTH  operand A; latched with start.
- b  input  WIDTH  operand B; latched with start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result, carry_out and ovf are valid.
- result  output  WIDTH  sum or difference; held until the next accepted start.
- carry_out  output  1  final carry. For subtraction, 1 = no borrow (a >= b unsigned).
- ovf  output  1  signed overflow; present only with ADDSUB_OVF_EN.

Behaviour:
- Reset values: state IDLE; busy, done, carry_out and ovf 0; result 0; internal bit counter and operand registers 0.
- States and transitions:
  - IDLE: start=1 latches a, b and sub, then goes to RUN. start=0 stays in IDLE.
  - RUN: busy=1. Each cycle processes bit index cnt, from 0 up to WIDTH-1. After bit WIDTH-1 goes to DONE.
  - DONE: done=1 for exactly one cycle, then goes to IDLE. A start in this cycle is accepted and goes directly to RUN.
- Per-bit datapath:
  - Full-adder inputs: a_sh[0], b_sh[0] XOR sub_q, and the carry flip-flop.
  - The carry flip-flop is initialised to sub on the accepting edge (two's-complement +1 for subtraction).
  - The sum bit shifts into result from the MSB side; a_sh and b_sh shift right.
  - After WIDTH steps, result holds the full value with the LSB at bit 0.
- Latency: start high in cycle 0 → busy high in cycles 1..WIDTH → done high in cycle WIDTH+1.
- Back-to-back operations: minimum issue interval is WIDTH+1 cycles.
- Output visibility:
  - result and carry_out update only on the transition into DONE; partial values are never visible on result.
  - Outputs hold their last values from DONE until the next DONE.
- start while busy: ignored, with no effect on the operation in flight and no queueing.
- Operands change after start: no effect, because they are latched.
- Reset mid-operation: rst has priority over everything. The unit returns to IDLE with all outputs at reset values in the next cycle; no done is produced for the aborted operation.
- Arithmetic is modulo 2^WIDTH. carry_out is the carry out of bit WIDTH-1.

Optional Feature:
- ADDSUB_OVF_EN defined:
  - ovf port exists.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, captured with the MSB step.
  - ovf is updated in DONE alongside result and is reset to 0.
- ADDSUB_OVF_EN not defined: the ovf port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (arith_pkg):
  - State encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Op constants: OP_ADD=1'b0, OP_SUB=1'b1.
- One natural sub-module: the team's existing fulladder cell (a, b, carry_in → sum, carry_out), instantiated once for the per-bit step.
- The control FSM, counter and shift registers stay in serial_addsub.

Test Plan:
- Add, WIDTH=8: a=8'h01, b=8'h01, sub=0, start in cycle 0 → busy in cycles 1-8; done in cycle 9 with result=8'h02, carry_out=0.
- Add with carry: a=8'hFF, b=8'h01, sub=0 → result=8'h00, carry_out=1. With ADDSUB_OVF_EN, ovf=0.
- Subtract with borrow: a=8'h05, b=8'h07, sub=1 → result=8'hFE, carry_out=0. Then a=8'h07, b=8'h05 → result=8'h02, carry_out=1.
- Signed overflow (ADDSUB_OVF_EN): a=8'h7F, b=8'h01, sub=0 → result=8'h80, ovf=1. Then a=8'h80, b=8'h01, sub=1 → result=8'h7F, ovf=1.
- Ignored start and back-to-back issue:
  - Start a=3, b=4; pulse start with a=9, b=9 in cycle 4 → done in cycle 9 with result=8'h07.
  - Then start in cycle 9 (the DONE cycle) → second done in cycle 18.
- Reset mid-operation: rst=1 in cycle 5 of an add → cycle 6 has busy=0, done=0, result=0. No done pulse for 20 further cycles. A new add issued afterwards completes correctly.
